// File: rtl/fermi32_pkg.sv
// Shared widths and the writeback entry type for the register-file write path.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package fermi32_pkg;

    localparam int XLEN     = 32;
    localparam int REG_AW   = 5;
    localparam int WB_DEPTH = 4;

    // One pending register-file write: destination register and its result.
    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } wb_entry_t;

    // Occupancy counter width: one extra bit so that 0..depth is representable.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// In-order storage for pending writebacks with wrap-bit pointers and an entry valid vector.
// Latency: push visible at the head one edge after acceptance; pop on the edge it is requested.
// Backpressure: push ignored when full, pop ignored when empty; callers gate with full/empty.
module wb_fifo
    import fermi32_pkg::*;
#(
    parameter int AW    = REG_AW,
    parameter int XLEN  = fermi32_pkg::XLEN,
    parameter int DEPTH = WB_DEPTH,
    parameter int PW    = $clog2(DEPTH),
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        push_i,
    input  logic [AW-1:0]               push_rd_i,
    input  logic [XLEN-1:0]             push_data_i,
    input  logic                        pop_i,
    output logic                        full_o,
    output logic                        empty_o,
    output logic [CW-1:0]               count_o,
    output logic [AW-1:0]               head_rd_o,
    output logic [XLEN-1:0]             head_data_o,
    output logic [PW-1:0]               tail_idx_o,
    output logic [DEPTH-1:0][AW-1:0]    ent_rd_o,
    output logic [DEPTH-1:0][XLEN-1:0]  ent_data_o,
    output logic [DEPTH-1:0]            ent_vld_o
);

    logic [CW-1:0]              wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]              rd_ptr_q, rd_ptr_d;
    logic [DEPTH-1:0][AW-1:0]   rd_mem_q;
    logic [DEPTH-1:0][XLEN-1:0] data_mem_q;
    logic                       do_push;
    logic                       do_pop;

    // Status flags and pointer advance; the wrap bit tells full apart from empty.
    always_comb begin
        full_o   = (wr_ptr_q[CW-1] != rd_ptr_q[CW-1]) &&
                   (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
        empty_o  = (wr_ptr_q == rd_ptr_q);
        count_o  = wr_ptr_q - rd_ptr_q;
        do_push  = push_i && !full_o;
        do_pop   = pop_i && !empty_o;
        wr_ptr_d = wr_ptr_q + (do_push ? CW'(1) : CW'(0));
        rd_ptr_d = rd_ptr_q + (do_pop  ? CW'(1) : CW'(0));
    end

    // Pointer registers; reset discards every queued entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Entry storage needs no reset: only slots covered by the pointers are ever read as valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            rd_mem_q[wr_ptr_q[PW-1:0]]   <= push_rd_i;
            data_mem_q[wr_ptr_q[PW-1:0]] <= push_data_i;
        end
    end

    // Expose head, tail slot and per-slot validity for the forwarding search.
    always_comb begin
        head_rd_o   = rd_mem_q[rd_ptr_q[PW-1:0]];
        head_data_o = data_mem_q[rd_ptr_q[PW-1:0]];
        tail_idx_o  = wr_ptr_q[PW-1:0];
        ent_rd_o    = rd_mem_q;
        ent_data_o  = data_mem_q;
        ent_vld_o   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ent_vld_o[i] = ({1'b0, PW'(i) - rd_ptr_q[PW-1:0]} < count_o);
        end
    end

endmodule

// File: rtl/regfile_wb_queue.sv
// Writeback front end: arbitrates ALU/load results into an in-order queue, drains one per cycle to WE3/A3/WD3, forwards pending data to A1/A2.
// Latency: accepted at edge N -> WE3 in cycle N..N+1 -> register file written at edge N+1 (empty queue, no stall).
// Backpressure: ready drops only on full (no same-cycle pop pass-through); load has priority over ALU; wb_stall holds the queue.
module regfile_wb_queue
    import fermi32_pkg::*;
#(
    parameter int XLEN  = fermi32_pkg::XLEN,
    parameter int AW    = REG_AW,
    parameter int DEPTH = WB_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     mem_valid,
    output logic                     mem_ready,
    input  logic [AW-1:0]            mem_rd,
    input  logic [XLEN-1:0]          mem_data,
    input  logic                     alu_valid,
    output logic                     alu_ready,
    input  logic [AW-1:0]            alu_rd,
    input  logic [XLEN-1:0]          alu_data,
    input  logic                     wb_stall,
    output logic                     WE3,
    output logic [AW-1:0]            A3,
    output logic [XLEN-1:0]          WD3,
    input  logic [AW-1:0]            A1,
    input  logic [AW-1:0]            A2,
    output logic                     fwd1_hit,
    output logic [XLEN-1:0]          fwd1_data,
    output logic                     fwd2_hit,
    output logic [XLEN-1:0]          fwd2_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    logic                       full;
    logic                       empty;
    logic [CW-1:0]              fifo_count;
    logic [AW-1:0]              head_rd;
    logic [XLEN-1:0]            head_data;
    logic [PW-1:0]              tail_idx;
    logic [DEPTH-1:0][AW-1:0]   ent_rd;
    logic [DEPTH-1:0][XLEN-1:0] ent_data;
    logic [DEPTH-1:0]           ent_vld;
    logic                       push_acc;
    logic                       push_en;
    logic [AW-1:0]              sel_rd;
    logic [XLEN-1:0]            sel_data;

    // Youngest valid entry matching addr; x0 never hits. Scanning oldest-first lets the youngest overwrite.
    function automatic logic [XLEN:0] fwd_search(
        input logic [AW-1:0]              addr,
        input logic [PW-1:0]              tail,
        input logic [DEPTH-1:0]           vld,
        input logic [DEPTH-1:0][AW-1:0]   rds,
        input logic [DEPTH-1:0][XLEN-1:0] datas
    );
        logic [XLEN:0] res;
        logic [PW-1:0] idx;
        res = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            idx = tail - PW'(1) - PW'(k);
            if ((addr != '0) && vld[idx] && (rds[idx] == addr)) begin
                res = {1'b1, datas[idx]};
            end
        end
        return res;
    endfunction

    wb_fifo #(
        .AW    (AW),
        .XLEN  (XLEN),
        .DEPTH (DEPTH),
        .PW    (PW),
        .CW    (CW)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (push_en),
        .push_rd_i   (sel_rd),
        .push_data_i (sel_data),
        .pop_i       (WE3),
        .full_o      (full),
        .empty_o     (empty),
        .count_o     (fifo_count),
        .head_rd_o   (head_rd),
        .head_data_o (head_data),
        .tail_idx_o  (tail_idx),
        .ent_rd_o    (ent_rd),
        .ent_data_o  (ent_data),
        .ent_vld_o   (ent_vld)
    );

    // Fixed-priority arbitration (load over ALU) and x0 filter: x0 writes handshake but are dropped.
    always_comb begin
        mem_ready = !full;
        alu_ready = !full && !mem_valid;
        sel_rd    = mem_valid ? mem_rd   : alu_rd;
        sel_data  = mem_valid ? mem_data : alu_data;
        push_acc  = (mem_valid && mem_ready) || (alu_valid && alu_ready);
        push_en   = push_acc && (sel_rd != '0);
    end

    // Drain the head straight onto the write port; address and data read as zero when idle.
    always_comb begin
        WE3   = !empty && !wb_stall;
        A3    = empty ? '0 : head_rd;
        WD3   = empty ? '0 : head_data;
        count = fifo_count;
    end

    // Forwarding of still-queued results to both decode read ports, head included.
    always_comb begin
        {fwd1_hit, fwd1_data} = fwd_search(A1, tail_idx, ent_vld, ent_rd, ent_data);
        {fwd2_hit, fwd2_data} = fwd_search(A2, tail_idx, ent_vld, ent_rd, ent_data);
    end

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Self-checking bench: directed sequences plus a scoreboard of accepted writes compared on every WE3.
// Latency: inputs driven 1ns after the rising edge, outputs sampled on the falling edge.
// Backpressure: exercised via wb_stall, full queue and simultaneous load/ALU requests.
module tb_regfile_wb_queue;
    import fermi32_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              mem_valid, mem_ready, alu_valid, alu_ready, wb_stall;
    logic [4:0]        mem_rd, alu_rd, A1, A2, A3;
    logic [31:0]       mem_data, alu_data, WD3, fwd1_data, fwd2_data;
    logic              WE3, fwd1_hit, fwd2_hit;
    logic [2:0]        count;

    int                n_checks = 0;
    int                n_errors = 0;
    int                n_writes = 0;
    wb_entry_t         sb[$];

    regfile_wb_queue dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_rd    (mem_rd),
        .mem_data  (mem_data),
        .alu_valid (alu_valid),
        .alu_ready (alu_ready),
        .alu_rd    (alu_rd),
        .alu_data  (alu_data),
        .wb_stall  (wb_stall),
        .WE3       (WE3),
        .A3        (A3),
        .WD3       (WD3),
        .A1        (A1),
        .A2        (A2),
        .fwd1_hit  (fwd1_hit),
        .fwd1_data (fwd1_data),
        .fwd2_hit  (fwd2_hit),
        .fwd2_data (fwd2_data),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: retire on WE3 first (it reflects pre-edge contents), then record this cycle's handshake.
    always @(negedge clk) begin
        if (rst_n) begin
            if (WE3) begin
                n_writes++;
                if (sb.size() == 0) begin
                    check("wb_unexpected", 1, 0);
                end else begin
                    wb_entry_t e;
                    e = sb.pop_front();
                    check("wb_A3", 64'(A3), 64'(e.rd));
                    check("wb_WD3", 64'(WD3), 64'(e.data));
                end
            end
            if (mem_valid && mem_ready) begin
                if (mem_rd != 0) sb.push_back('{rd: mem_rd, data: mem_data});
            end else if (alu_valid && alu_ready) begin
                if (alu_rd != 0) sb.push_back('{rd: alu_rd, data: alu_data});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [4:0]  t4_rd [4];
        logic [31:0] t4_dat[4];
        logic [4:0]  t4_exp[5];
        t4_rd  = '{5'd7, 5'd7, 5'd9, 5'd2};
        t4_dat = '{32'hA, 32'hB, 32'hC, 32'hD};
        t4_exp = '{5'd7, 5'd7, 5'd9, 5'd2, 5'd6};

        rst_n = 1'b0; mem_valid = 0; alu_valid = 0; wb_stall = 0;
        mem_rd = 0; mem_data = 0; alu_rd = 0; alu_data = 0; A1 = 0; A2 = 0;

        // 1: reset state and readiness after release
        repeat (2) @(negedge clk);
        check("rst_count", 64'(count), 0);
        check("rst_we3", 64'(WE3), 0);
        check("rst_a3", 64'(A3), 0);
        check("rst_wd3", 64'(WD3), 0);
        check("rst_fwd1", 64'(fwd1_hit), 0);
        check("rst_fwd2", 64'(fwd2_hit), 0);
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        check("rel_mem_ready", 64'(mem_ready), 1);
        check("rel_alu_ready", 64'(alu_ready), 1);

        // 2: single ALU write, one-cycle latency to WE3
        tick();
        alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF;
        @(negedge clk);
        check("t2_alu_ready", 64'(alu_ready), 1);
        tick();
        alu_valid = 0;
        @(negedge clk);
        check("t2_we3", 64'(WE3), 1);
        check("t2_a3", 64'(A3), 5);
        check("t2_wd3", 64'(WD3), 32'hDEADBEEF);
        tick();
        @(negedge clk);
        check("t2_we3_off", 64'(WE3), 0);
        check("t2_count", 64'(count), 0);

        // 3: load has priority, ALU follows, writes land in order 3 then 4
        tick();
        mem_valid = 1; mem_rd = 3; mem_data = 32'h11;
        alu_valid = 1; alu_rd = 4; alu_data = 32'h22;
        @(negedge clk);
        check("t3_mem_ready", 64'(mem_ready), 1);
        check("t3_alu_ready", 64'(alu_ready), 0);
        tick();
        mem_valid = 0;
        @(negedge clk);
        check("t3_alu_ready2", 64'(alu_ready), 1);
        check("t3_a3_first", 64'(A3), 3);
        tick();
        alu_valid = 0;
        @(negedge clk);
        check("t3_a3_second", 64'(A3), 4);
        check("t3_count", 64'(count), 1);
        tick();
        @(negedge clk);
        check("t3_idle", 64'(WE3), 0);

        // 4: fill under stall, forwarding picks youngest, then drain in order
        tick();
        wb_stall = 1;
        for (int i = 0; i < 4; i++) begin
            alu_valid = 1; alu_rd = t4_rd[i]; alu_data = t4_dat[i];
            tick();
        end
        alu_valid = 0; A1 = 7; A2 = 8;
        @(negedge clk);
        check("t4_count", 64'(count), 4);
        check("t4_mem_ready", 64'(mem_ready), 0);
        check("t4_alu_ready", 64'(alu_ready), 0);
        check("t4_we3_stall", 64'(WE3), 0);
        check("t4_fwd1_hit", 64'(fwd1_hit), 1);
        check("t4_fwd1_data", 64'(fwd1_data), 32'hB);
        check("t4_fwd2_hit", 64'(fwd2_hit), 0);
        check("t4_fwd2_data", 64'(fwd2_data), 0);
        #1; A1 = 2; A2 = 9; #1;
        check("t4_fwd1_tail", 64'(fwd1_data), 32'hD);
        check("t4_fwd2_mid", 64'(fwd2_data), 32'hC);
        tick();
        wb_stall = 0; A1 = 0; A2 = 0;
        mem_valid = 1; mem_rd = 6; mem_data = 32'hE;
        @(negedge clk);
        check("t4_full_pop_ready", 64'(mem_ready), 0);
        for (int i = 0; i < 5; i++) begin
            check("t4_drain_we3", 64'(WE3), 1);
            check("t4_drain_a3", 64'(A3), 64'(t4_exp[i]));
            if (i == 1) check("t4_ready_after_pop", 64'(mem_ready), 1);
            if (i == 4) begin
                check("t4_head_fwd_hit", 64'(fwd1_hit), 1);
                check("t4_head_fwd_data", 64'(fwd1_data), 32'hE);
                check("t4_last_count", 64'(count), 1);
            end
            tick();
            if (i == 1) mem_valid = 0;
            if (i == 3) A1 = 6;
            @(negedge clk);
        end
        check("t4_drained_we3", 64'(WE3), 0);
        check("t4_drained_fwd", 64'(fwd1_hit), 0);

        // 5: x0 destination handshakes but never queues or forwards
        tick();
        A1 = 0;
        alu_valid = 1; alu_rd = 0; alu_data = 32'h55;
        @(negedge clk);
        check("t5_alu_ready", 64'(alu_ready), 1);
        check("t5_fwd1_x0", 64'(fwd1_hit), 0);
        tick();
        alu_valid = 0;
        @(negedge clk);
        check("t5_count", 64'(count), 0);
        check("t5_we3", 64'(WE3), 0);

        // 6: asynchronous reset mid-cycle discards queued entries
        tick();
        wb_stall = 1;
        for (int i = 0; i < 3; i++) begin
            alu_valid = 1; alu_rd = 5'(10 + i); alu_data = 32'(256 + i);
            tick();
        end
        alu_valid = 0; A1 = 10;
        @(negedge clk);
        check("t6_count_pre", 64'(count), 3);
        check("t6_fwd_pre", 64'(fwd1_hit), 1);
        #2;
        rst_n = 1'b0;
        sb.delete();
        #1;
        check("t6_count_rst", 64'(count), 0);
        check("t6_we3_rst", 64'(WE3), 0);
        check("t6_fwd_rst", 64'(fwd1_hit), 0);
        tick();
        rst_n = 1'b1; wb_stall = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t6_we3_post", 64'(WE3), 0);
            check("t6_count_post", 64'(count), 0);
        end

        // End: every accepted non-x0 write retired exactly once
        tick();
        @(negedge clk);
        check("sb_drained", 64'(sb.size()), 0);
        check("total_writes", 64'(n_writes), 8);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
